serial_word_deserializer: RTL and testbench
===========================================

# serial_word_deserializer

Receive-side counterpart of the universal shift register in its serial-out role. The block samples a qualified serial bit stream, assembles DATA_WIDTH-bit words MSB-first or LSB-first, and presents each word on a one-entry parallel output buffer with a valid/ready handshake. It sits between any serial source (shift-register transmitter, serial link) and a parallel consumer, and reports dropped words.

## Interface
- DATA_WIDTH, 8, word length in bits (>= 2)
- Clk_In  input  1  clock; all logic on rising edge
- Reset_In  input  1  synchronous, active-high reset
- Serial_Data_In  input  1  serial bit, sampled only when Serial_Valid_In=1
- Serial_Valid_In  input  1  qualifies Serial_Data_In for this cycle
- Shift_Dir_In  input  1  0 = MSB first (shift left, enter at bit 0); 1 = LSB first (shift right, enter at bit DATA_WIDTH-1)
- Sync_In  input  1  abort the partial word and restart bit count
- Data_Ready_In  input  1  consumer accepts the output word
- Parallel_Data_Out  output  DATA_WIDTH  assembled word, held while Data_Valid_Out=1
- Data_Valid_Out  output  1  output buffer holds an unconsumed word
- Busy_Out  output  1  partial word in progress (state RECEIVE)
- Overrun_Out  output  1  sticky: a completed word was dropped
- Parity_Error_Out  output  1  sticky parity failure (only with PARITY_CHECK_EN)

## Operation
- Reset values: Parallel_Data_Out=0, Data_Valid_Out=0, Busy_Out=0, Overrun_Out=0, Parity_Error_Out=0, bit count 0, shift register 0, state IDLE.
- States: IDLE (no bits held), RECEIVE (1..DATA_WIDTH-1 bits held), PARITY (macro only: data complete, awaiting parity bit).
- IDLE -> RECEIVE on first valid bit; Shift_Dir_In is latched at that bit and is ignored for the rest of the word.
- RECEIVE: each valid bit shifts in, count increments; on the DATA_WIDTH-th bit the word completes -> IDLE (or PARITY with the macro).
- Word completion: if the buffer is empty, or Data_Valid_Out & Data_Ready_In in the same cycle, the new word loads and Data_Valid_Out=1. Otherwise the word is dropped, the buffer keeps the old word, and Overrun_Out is set.
- Handshake: the word is consumed on the edge where Data_Valid_Out & Data_Ready_In; Data_Valid_Out then clears unless a new word loads on that same edge.
- Sync_In: clears count and partial word -> IDLE. If Serial_Valid_In is also high, that bit becomes bit 1 of the new word (Shift_Dir_In latched). Sync_In does not affect the output buffer or the sticky flags.
- Cycles with Serial_Valid_In=0 hold all state; gaps of any length are allowed.
- Overrun_Out and Parity_Error_Out clear only on Reset_In.

## Timing
- Last data bit sampled at edge N -> Parallel_Data_Out/Data_Valid_Out valid after edge N (latency 1 edge, registered outputs).
- Max throughput: one bit per cycle, back-to-back words with no idle cycle.
- Reset_In during a word: partial word is discarded and all outputs reach reset values after that edge; Reset_In has priority over every other input.

## Configuration
- PARITY_CHECK_EN defined: the frame is DATA_WIDTH data bits followed by one even-parity bit. The word loads only after the parity bit is sampled (latency counted from the parity bit). On mismatch the word still loads and Parity_Error_Out is set.
- PARITY_CHECK_EN undefined: no PARITY state; the frame is DATA_WIDTH bits; Parity_Error_Out is tied to 0.

## Structure
- Shared package: state enum (IDLE, RECEIVE, PARITY), direction constants DIR_MSB_FIRST=0 and DIR_LSB_FIRST=1.
- One sub-module: serial_shift_in_register. It is DATA_WIDTH wide and provides shift-left-in, shift-right-in, clear, and hold. The top level owns the FSM, bit counter, output buffer, and flags.

## Test plan
- MSB first: send bits 0,0,0,1,1,1,1,0 on consecutive cycles with Data_Ready_In=1 -> Parallel_Data_Out=8'h1E, Data_Valid_Out=1 one cycle after the 8th edge.
- LSB first: send the same bit sequence with Shift_Dir_In=1 -> 8'h78. Toggling Shift_Dir_In mid-word gives the same result.
- Gaps: the 8'h1E sequence with Serial_Valid_In=0 on random cycles between bits -> 8'h1E, Busy_Out=1 throughout the gaps.
- Overrun: Data_Ready_In=0, send 8'h1E then 8'hFF -> output stays 8'h1E and Overrun_Out=1. Then raise Data_Ready_In -> Data_Valid_Out=0 next cycle while Overrun_Out stays 1.
- Sync/reset: 3 bits, then Sync_In, then 8'h55 -> 8'h55. Separately, 5 bits then Reset_In -> all outputs 0, and the next 8 bits form a clean word.
- With PARITY_CHECK_EN: 8'h1E plus parity 0 -> no error; 8'h1E plus parity 1 -> word loads and Parity_Error_Out=1.

Source files
------------

// File: rtl/serial_word_deserializer_pkg.sv
// Shared definitions for the serial word deserializer.
//   state_e        : receive FSM states (IDLE, RECEIVE, PARITY)
//   DIR_MSB_FIRST  : Shift_Dir_In value for MSB-first words (shift left)
//   DIR_LSB_FIRST  : Shift_Dir_In value for LSB-first words (shift right)
package serial_word_deserializer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        PARITY  = 2'd2
    } state_e;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_shift_in_register.sv
// DATA_WIDTH-bit shift-in register with clear, hold, shift-left-in and
// shift-right-in. Clear and shift may be asserted together: the incoming
// bit then enters an all-zero register (start of a fresh word).
//   clk_i, rst_i : clock, synchronous active-high reset
//   clear_i      : discard held bits
//   shift_en_i   : shift bit_i in this cycle (otherwise hold)
//   dir_i        : DIR_MSB_FIRST enters at bit 0, DIR_LSB_FIRST at the MSB
//   data_o       : current register contents
//   next_o       : contents after this edge (used to capture a finished word)
module serial_shift_in_register
    import serial_word_deserializer_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  shift_en_i,
    input  logic                  dir_i,
    input  logic                  bit_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [DATA_WIDTH-1:0] next_o
);

    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic [DATA_WIDTH-1:0] base_s;

    // Next-value selection: clear first, then optionally shift one bit in.
    always_comb begin
        base_s = clear_i ? '0 : data_q;
        if (shift_en_i) begin
            if (dir_i == DIR_LSB_FIRST) begin
                data_d = {bit_i, base_s[DATA_WIDTH-1:1]};
            end else begin
                data_d = {base_s[DATA_WIDTH-2:0], bit_i};
            end
        end else begin
            data_d = base_s;
        end
    end

    // Shift register state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;
    assign next_o = data_d;

endmodule

// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel word receiver with a one-entry valid/ready output buffer.
// Bits qualified by Serial_Valid_In are assembled MSB- or LSB-first (direction
// latched at the first bit of each word); completed words that find the buffer
// full are dropped and flagged on the sticky Overrun_Out.
// Optional feature macro: PARITY_CHECK_EN adds a trailing even-parity bit per
// frame and a sticky Parity_Error_Out; without it Parity_Error_Out stays 0.
// Ports:
//   Clk_In, Reset_In         : clock, synchronous active-high reset
//   Serial_Data_In/Valid_In  : qualified serial input
//   Shift_Dir_In             : 0 MSB first, 1 LSB first
//   Sync_In                  : abandon the partial word
//   Data_Ready_In            : consumer accepts Parallel_Data_Out
//   Parallel_Data_Out        : buffered word
//   Data_Valid_Out           : buffer holds an unconsumed word
//   Busy_Out                 : partial frame in progress
//   Overrun_Out              : sticky, a completed word was dropped
//   Parity_Error_Out         : sticky parity failure
module serial_word_deserializer
    import serial_word_deserializer_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic                  Serial_Data_In,
    input  logic                  Serial_Valid_In,
    input  logic                  Shift_Dir_In,
    input  logic                  Sync_In,
    input  logic                  Data_Ready_In,
    output logic [DATA_WIDTH-1:0] Parallel_Data_Out,
    output logic                  Data_Valid_Out,
    output logic                  Busy_Out,
    output logic                  Overrun_Out,
    output logic                  Parity_Error_Out
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

`ifdef PARITY_CHECK_EN
    // Even parity: data ones plus the parity bit must be even.
    function automatic logic parity_ok(input logic [DATA_WIDTH-1:0] word,
                                       input logic par);
        return ~(^word ^ par);
    endfunction
`endif

    state_e                state_q,   state_d;
    logic [CNT_W-1:0]      count_q,   count_d;
    logic                  dir_q,     dir_d;
    logic [DATA_WIDTH-1:0] data_q,    data_d;
    logic                  valid_q,   valid_d;
    logic                  busy_q,    busy_d;
    logic                  overrun_q, overrun_d;
    logic                  perr_q,    perr_d;

    logic                  sr_clear_s;
    logic                  sr_shift_s;
    logic [DATA_WIDTH-1:0] sr_data_s;
    logic [DATA_WIDTH-1:0] sr_next_s;
    logic                  complete_s;
    logic [DATA_WIDTH-1:0] word_s;
    logic                  perr_hit_s;
    logic                  consume_s;

    // dir_d already selects the live input at a word start and the latched
    // direction mid-word, so it drives the shifter directly.
    serial_shift_in_register #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shift (
        .clk_i      (Clk_In),
        .rst_i      (Reset_In),
        .clear_i    (sr_clear_s),
        .shift_en_i (sr_shift_s),
        .dir_i      (dir_d),
        .bit_i      (Serial_Data_In),
        .data_o     (sr_data_s),
        .next_o     (sr_next_s)
    );

    // Frame FSM: bit counting, direction latch and word completion.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        dir_d      = dir_q;
        sr_clear_s = 1'b0;
        sr_shift_s = 1'b0;
        complete_s = 1'b0;
        word_s     = sr_next_s;
        perr_hit_s = 1'b0;
        if (Sync_In) begin
            // Abort; a simultaneous valid bit opens the next word.
            sr_clear_s = 1'b1;
            if (Serial_Valid_In) begin
                sr_shift_s = 1'b1;
                dir_d      = Shift_Dir_In;
                count_d    = CNT_W'(1);
                state_d    = RECEIVE;
            end else begin
                count_d = '0;
                state_d = IDLE;
            end
        end else if (Serial_Valid_In) begin
            case (state_q)
                IDLE: begin
                    sr_clear_s = 1'b1;
                    sr_shift_s = 1'b1;
                    dir_d      = Shift_Dir_In;
                    count_d    = CNT_W'(1);
                    state_d    = RECEIVE;
                end
                RECEIVE: begin
                    sr_shift_s = 1'b1;
                    if (count_q == LAST_CNT) begin
                        count_d = '0;
`ifdef PARITY_CHECK_EN
                        state_d = PARITY;
`else
                        complete_s = 1'b1;
                        state_d    = IDLE;
`endif
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                PARITY: begin
`ifdef PARITY_CHECK_EN
                    // Data bits are complete and held; this bit is parity.
                    complete_s = 1'b1;
                    word_s     = sr_data_s;
                    perr_hit_s = ~parity_ok(sr_data_s, Serial_Data_In);
`endif
                    count_d = '0;
                    state_d = IDLE;
                end
                default: begin
                    count_d = '0;
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output buffer, handshake and sticky flags.
    always_comb begin
        consume_s = valid_q & Data_Ready_In;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        perr_d    = perr_q | perr_hit_s;
        busy_d    = (state_d != IDLE);
        if (complete_s) begin
            if (!valid_q || consume_s) begin
                data_d  = word_s;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (consume_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            state_q   <= IDLE;
            count_q   <= '0;
            dir_q     <= DIR_MSB_FIRST;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            dir_q     <= dir_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            perr_q    <= perr_d;
        end
    end

    assign Parallel_Data_Out = data_q;
    assign Data_Valid_Out    = valid_q;
    assign Busy_Out          = busy_q;
    assign Overrun_Out       = overrun_q;
    assign Parity_Error_Out  = perr_q;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Self-checking bench for serial_word_deserializer (DATA_WIDTH = 8).
// Table-driven vectors, directed multi-cycle sequences, then random stimulus
// compared against a bit-queue reference model.
module tb_serial_word_deserializer;

    localparam int W = 8;
`ifdef PARITY_CHECK_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sd = 1'b0;
    logic         sv = 1'b0;
    logic         dir = 1'b0;
    logic         sync = 1'b0;
    logic         ready = 1'b0;
    logic [W-1:0] pdata;
    logic         pvalid;
    logic         busy;
    logic         ovr;
    logic         perr;

    always #5 clk = ~clk;

    serial_word_deserializer #(.DATA_WIDTH(W)) dut (
        .Clk_In            (clk),
        .Reset_In          (rst),
        .Serial_Data_In    (sd),
        .Serial_Valid_In   (sv),
        .Shift_Dir_In      (dir),
        .Sync_In           (sync),
        .Data_Ready_In     (ready),
        .Parallel_Data_Out (pdata),
        .Data_Valid_Out    (pvalid),
        .Busy_Out          (busy),
        .Overrun_Out       (ovr),
        .Parity_Error_Out  (perr)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: received bits of the current frame plus the buffer.
    bit           mb[$];
    logic         mdir = 1'b0;
    logic [W-1:0] mdata = '0;
    logic         mvalid = 1'b0;
    logic         movr = 1'b0;
    logic         mperr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        logic         consume;
        logic         done;
        logic [W-1:0] w;
        int           ones;
        consume = mvalid && ready;
        done = 1'b0;
        w = '0;
        ones = 0;
        if (rst) begin
            mb.delete();
            mdata = '0;
            mvalid = 1'b0;
            movr = 1'b0;
            mperr = 1'b0;
        end else begin
            if (sync) mb.delete();
            if (sv) begin
                if (mb.size() == 0) mdir = dir;
                mb.push_back(sd);
                if (mb.size() == FRAME) begin
                    done = 1'b1;
                    for (int i = 0; i < W; i++) begin
                        if (mdir == 1'b0) w = w + (W'(mb[i]) << (W - 1 - i));
                        else              w = w + (W'(mb[i]) << i);
                    end
                    foreach (mb[k]) ones += int'(mb[k]);
                    if (FRAME > W && (ones % 2) != 0) mperr = 1'b1;
                    mb.delete();
                end
            end
            if (done) begin
                if (!mvalid || consume) begin
                    mdata = w;
                    mvalid = 1'b1;
                end else begin
                    movr = 1'b1;
                end
            end else if (consume) begin
                mvalid = 1'b0;
            end
        end
    endtask

    // Drive one cycle, clock it, and compare every output with the model.
    task automatic step(input logic v, input logic d, input logic di,
                        input logic sy, input logic rd, input logic rs);
        sv = v; sd = d; dir = di; sync = sy; ready = rd; rst = rs;
        model_edge();
        @(posedge clk);
        #1;
        chk("m_data",  32'(pdata),  32'(mdata));
        chk("m_valid", 32'(pvalid), 32'(mvalid));
        chk("m_busy",  32'(busy),   32'(mb.size() != 0));
        chk("m_ovr",   32'(ovr),    32'(movr));
        chk("m_perr",  32'(perr),   32'(mperr));
    endtask

    // Send nbits of seq (most significant of those first in time), with
    // optional random gaps; Busy_Out must stay high inside a frame's gaps.
    task automatic send_bits(input logic [8:0] seq, input int nbits, input logic di,
                             input logic rd, input int gapmax, input logic sync_first);
        for (int i = 0; i < nbits; i++) begin
            if (i > 0) begin
                repeat ($urandom_range(0, gapmax)) begin
                    step(1'b0, 1'b0, di, 1'b0, rd, 1'b0);
                    chk("gap_busy", 32'(busy), 32'd1);
                end
            end
            step(1'b1, seq[nbits-1-i], di, (i == 0) ? sync_first : 1'b0, rd, 1'b0);
        end
    endtask

    typedef struct {
        logic         v, d, di, sy, rd, rs;
        logic [W-1:0] e_data;
        logic         e_valid, e_busy, e_ovr;
    } vec_t;

    vec_t tbl[18];

    initial begin
        logic [7:0] pat;
        pat = 8'h1E;
        // Row 0: reset. Rows 1-8: MSB-first 0,0,0,1,1,1,1,0. Rows 9-16: the
        // same bits LSB-first with Shift_Dir_In toggling after the first bit.
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        for (int i = 1; i <= 8; i++)
            tbl[i] = '{1'b1, pat[8-i], 1'b0, 1'b0, 1'b1, 1'b0,
                       (i == 8) ? 8'h1E : 8'h00, i == 8, i != 8, 1'b0};
        for (int i = 9; i <= 16; i++)
            tbl[i] = '{1'b1, pat[16-i], (i == 9) ? 1'b1 : 1'(i % 2), 1'b0, 1'b1, 1'b0,
                       (i == 16) ? 8'h78 : 8'h1E, i == 16, i != 16, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h78, 1'b0, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;

`ifndef PARITY_CHECK_EN
        foreach (tbl[r]) begin
            step(tbl[r].v, tbl[r].d, tbl[r].di, tbl[r].sy, tbl[r].rd, tbl[r].rs);
            chk($sformatf("t%0d_data", r),  32'(pdata),  32'(tbl[r].e_data));
            chk($sformatf("t%0d_valid", r), 32'(pvalid), 32'(tbl[r].e_valid));
            chk($sformatf("t%0d_busy", r),  32'(busy),   32'(tbl[r].e_busy));
            chk($sformatf("t%0d_ovr", r),   32'(ovr),    32'(tbl[r].e_ovr));
        end

        // Overrun: second word is dropped while the consumer stalls.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_bits(9'h1E, 8, 1'b0, 1'b0, 0, 1'b0);
        chk("ovr_first", 32'(pdata), 32'h1E);
        send_bits(9'hFF, 8, 1'b0, 1'b0, 0, 1'b0);
        chk("ovr_keep",  32'(pdata),  32'h1E);
        chk("ovr_flag",  32'(ovr),    32'd1);
        chk("ovr_valid", 32'(pvalid), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovr_drain", 32'(pvalid), 32'd0);
        chk("ovr_stick", 32'(ovr),    32'd1);

        // Gaps between bits.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_bits(9'h1E, 8, 1'b0, 1'b1, 3, 1'b0);
        chk("gap_data",  32'(pdata),  32'h1E);
        chk("gap_valid", 32'(pvalid), 32'd1);

        // Sync alone, then a word; sync carrying the first bit of a word.
        send_bits(9'h005, 3, 1'b0, 1'b1, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("sync_idle", 32'(busy), 32'd0);
        send_bits(9'h55, 8, 1'b0, 1'b1, 0, 1'b0);
        chk("sync_55", 32'(pdata), 32'h55);
        send_bits(9'h003, 3, 1'b0, 1'b1, 0, 1'b0);
        send_bits(9'hA5, 8, 1'b0, 1'b1, 0, 1'b1);
        chk("sync_a5", 32'(pdata), 32'hA5);

        // Reset mid-word, then a clean word.
        send_bits(9'h01B, 5, 1'b0, 1'b1, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("rst_data",  32'(pdata),  32'd0);
        chk("rst_valid", 32'(pvalid), 32'd0);
        chk("rst_busy",  32'(busy),   32'd0);
        send_bits(9'h3C, 8, 1'b0, 1'b1, 0, 1'b0);
        chk("rst_clean", 32'(pdata),  32'h3C);
        chk("rst_cval",  32'(pvalid), 32'd1);
`else
        // Parity frames: 8'h1E has four ones, so parity bit 0 is correct.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_bits({8'h1E, 1'b0}, 9, 1'b0, 1'b1, 0, 1'b0);
        chk("par_ok_data", 32'(pdata), 32'h1E);
        chk("par_ok_err",  32'(perr),  32'd0);
        send_bits({8'h1E, 1'b1}, 9, 1'b0, 1'b1, 0, 1'b0);
        chk("par_bad_data",  32'(pdata),  32'h1E);
        chk("par_bad_valid", 32'(pvalid), 32'd1);
        chk("par_bad_err",   32'(perr),   32'd1);
`endif

        // Random stimulus against the model.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 4) != 0, 1'($urandom), 1'($urandom),
                 ($urandom % 64) == 0, ($urandom % 3) != 0, ($urandom % 500) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
